score_sched: RTL

Scheduler that shares the three-digit BCD score counter between several game-event requesters. Each requester posts hits carrying a point value. The block accumulates pending points per requester and picks requesters round-robin. It drives the counter's increment strobe with exactly one single-cycle pulse per point, spaced so each pulse presents a clean rising edge. It sits between the game-object collision logic and the score counter, and it also sequences score clears for a new game.

---
 rtl/score_pkg.sv | 16 +
 rtl/score_rr_arb.sv | 30 +++
 rtl/score_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and defaults for the score scheduler
package score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam int PTS_W         = 3;
    localparam int N_REQ_DEF     = 4;
    localparam int PEND_W_DEF    = 4;
    localparam int PULSE_GAP_DEF = 2;

endpackage

// File: rtl/score_rr_arb.sv
// rtl/score_rr_arb.sv - combinational round-robin select over nonzero accumulators
module score_rr_arb
    import score_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] nz,
    input  logic [IDX_W-1:0] last_gnt,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    logic [IDX_W-1:0] sel;

    // Scan from farthest to nearest after last_gnt so the nearest candidate is written last
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        sel       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sel = IDX_W'((int'(last_gnt) + k) % N_REQ);
            if (nz[sel]) begin
                winner    = sel;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_sched.sv
// rtl/score_sched.sv - round-robin point scheduler driving the BCD score counter (option: SCORE_SCHED_OVF_EN)
module score_sched
    import score_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int PEND_W    = PEND_W_DEF,
    parameter int PULSE_GAP = PULSE_GAP_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*PTS_W-1:0]   pts,
    input  logic                     clr,
    output logic                     inc,
    output logic                     cnt_clr,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     ovf
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
    localparam int SUM_W = PEND_W + 2;
    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);

    state_t             state, state_nx;
    logic [PEND_W-1:0]  pend    [N_REQ];
    logic [PEND_W-1:0]  pend_nx [N_REQ];
    logic [SUM_W-1:0]   sum     [N_REQ];
    logic [N_REQ-1:0]   nz, nz_nx;
    logic [IDX_W-1:0]   last_gnt, winner;
    logic               any_valid;
    logic               dec_en, zero_pend;
    logic               clr_pend, clr_pend_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_nx;

    score_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .nz        (nz),
        .last_gnt  (last_gnt),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Which requesters currently hold points
    always_comb begin
        nz = '0;
        for (int i = 0; i < N_REQ; i++) nz[i] = |pend[i];
    end

    // Next state: a new arbitration only happens from IDLE or the final GAP cycle
    always_comb begin
        state_nx    = state;
        gap_nx      = gap_cnt;
        clr_pend_nx = clr_pend;
        dec_en      = 1'b0;
        zero_pend   = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx  = CLEAR;
                    zero_pend = 1'b1;
                end else if (any_valid) begin
                    state_nx = GRANT;
                    dec_en   = 1'b1;
                end
            end
            GRANT: begin
                state_nx = GAP;
                gap_nx   = GAP_W'(PULSE_GAP - 1);
                if (clr) clr_pend_nx = 1'b1;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    if (clr || clr_pend) begin
                        state_nx    = CLEAR;
                        zero_pend   = 1'b1;
                        clr_pend_nx = 1'b0;
                    end else if (any_valid) begin
                        state_nx = GRANT;
                        dec_en   = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    gap_nx = gap_cnt - GAP_W'(1);
                    if (clr) clr_pend_nx = 1'b1;
                end
            end
            CLEAR: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Accumulator update: add hit points, take one for the winner, saturate; clear entry drops everything
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            sum[i] = SUM_W'(pend[i]);
            if (req[i]) sum[i] = sum[i] + SUM_W'(pts[i*PTS_W +: PTS_W]);
            if (dec_en && (winner == IDX_W'(i))) sum[i] = sum[i] - SUM_W'(1);
            if (zero_pend)
                pend_nx[i] = '0;
            else if (sum[i] > PEND_MAX)
                pend_nx[i] = PEND_MAX[PEND_W-1:0];
            else
                pend_nx[i] = sum[i][PEND_W-1:0];
            nz_nx[i] = |pend_nx[i];
        end
    end

    // State, accumulators and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            clr_pend <= 1'b0;
            last_gnt <= IDX_W'(N_REQ - 1);
            gnt_id   <= '0;
            inc      <= 1'b0;
            cnt_clr  <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < N_REQ; i++) pend[i] <= '0;
        end else begin
            state    <= state_nx;
            gap_cnt  <= gap_nx;
            clr_pend <= clr_pend_nx;
            for (int i = 0; i < N_REQ; i++) pend[i] <= pend_nx[i];
            if (dec_en) begin
                last_gnt <= winner;
                gnt_id   <= winner;
            end
            inc     <= (state_nx == GRANT);
            cnt_clr <= (state_nx == CLEAR);
            busy    <= (state_nx != IDLE) || (|nz_nx);
        end
    end

`ifdef SCORE_SCHED_OVF_EN
    logic ovf_hit;

    // Any accumulator that would have exceeded its maximum this cycle
    always_comb begin
        ovf_hit = 1'b0;
        for (int i = 0; i < N_REQ; i++)
            if (!zero_pend && (sum[i] > PEND_MAX)) ovf_hit = 1'b1;
    end

    // Sticky saturation flag, dropped when a clear starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ovf <= 1'b0;
        else if (zero_pend)
            ovf <= 1'b0;
        else if (ovf_hit)
            ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
